program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer-side counterpart to the accumulator CPU's 32x8 program/data RAM. The CPU only fetches from this RAM; this block fills it.
- Accepts a byte stream over a valid/ready handshake and writes it sequentially from address 0.
- Reads the image back and checks it against a running mod-256 checksum.
- Holds the CPU in reset until a verified image is present.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM word width (instruction = opcode[7:5] + operand[4:0]).
- DEPTH, 32, number of RAM words; legal load lengths are 1..DEPTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load using len.
- len  in  ADDR_W+1  number of words to load, sampled with start.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  DATA_W  byte to be written.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address, used for both write and read.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous, valid one cycle after mem_addr.
- cpu_hold  out  1  drives the CPU reset; 1 = CPU held.
- busy  out  1  high in LOAD, VERIFY and CHECK.
- done  out  1  verified image present.
- error  out  1  bad len or verify mismatch.
- checksum  out  DATA_W  mod-256 sum of the bytes written.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE. in_ready=0, mem_we=0, mem_addr=0, cpu_hold=1, busy=0, done=0, error=0, checksum=0, internal counters=0.
- Reset mid-load or mid-verify aborts to IDLE. RAM contents are left partial; cpu_hold stays 1.
- IDLE:
  - cpu_hold=1.
  - start with 1<=len<=DEPTH: latch len, clear addr and checksum, go to LOAD next cycle.
  - start with len=0 or len>DEPTH: go to ERROR next cycle.
- LOAD:
  - in_ready=1.
  - On a transfer (in_valid & in_ready): mem_we=1, mem_addr=addr, mem_wdata=in_data, all combinational in that cycle.
  - Same edge: checksum += in_data (mod 256), addr += 1.
  - No transfer: mem_we=0, no state change. Gaps in in_valid are allowed without limit.
  - Transfer at addr=len-1: go to VERIFY next cycle; in_ready=0 from that cycle on.
  - addr never wraps; no write occurs beyond len-1.
- VERIFY (pipelined readback):
  - Cycles 0..len-1: mem_addr = read index 0..len-1; mem_we=0.
  - Cycles 1..len: vsum += mem_rdata.
  - VERIFY therefore lasts len+1 cycles, then CHECK.
- CHECK (1 cycle): vsum==checksum goes to DONE, otherwise to ERROR.
- DONE:
  - done=1, cpu_hold=0, busy=0.
  - The CPU runs from its reset state.
- ERROR: error=1, cpu_hold=1, busy=0.
- In DONE or ERROR, start restarts exactly as from IDLE:
  - done and error clear on the next edge.
  - cpu_hold=1 from that same edge.
- start in LOAD, VERIFY or CHECK is ignored.
- Total latency from start to done for len words with no gaps: 1 + len + (len+1) + 1 edges.
  - Example: len=4 gives done on the 11th edge after start is sampled.
- checksum holds its value in DONE and ERROR until the next accepted start.

Test Plan:
- Load 4 bytes 0x05,0x86,0x25,0xC0 (ld 5, mp 6, st 5, ht), no gaps, ideal RAM model.
  - Writes land at addresses 0..3.
  - checksum=0x70; done=1 and cpu_hold=0 on edge 11 after start; error=0.
- Same 4 bytes with in_valid low for 3 cycles between bytes 2 and 3.
  - Exactly 4 mem_we pulses, at addresses 0,1,2,3.
  - checksum=0x70; done is delayed by 3 cycles.
- start with len=0, then start with len=33.
  - Each gives error=1, cpu_hold=1 and no mem_we.
  - A following start with len=1 and byte 0xC0 gives done=1, checksum=0xC0.
- len=32, bytes 0x00..0x1F.
  - Last write is at addr 31; in_ready=0 after the 32nd transfer.
  - No write to addr 0 after that; checksum=0xF0; done=1.
- RAM model forces address 2 to read back XOR 0x01.
  - CHECK goes to ERROR; error=1, cpu_hold=1, done=0.
- reset asserted after 3 of 4 bytes.
  - Next cycle: IDLE, in_ready=0, checksum=0, cpu_hold=1.
  - A fresh 4-byte load then completes with done=1.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and RAM-port bundle between the program loader and its neighbours.
// A byte moves on every rising clk edge where in_valid and in_ready are both high.
interface program_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output in_valid, in_data, mem_rdata,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, mem_rdata,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Fills the CPU's program RAM from a byte stream, reads the image back to verify
// its checksum, and keeps the CPU in reset until a verified image is present.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    program_loader_if.slave   bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [ADDR_W:0]   vcnt_q, vcnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] vsum_q, vsum_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              len_ok;
    logic              xfer;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign len_ok = (len != '0) && (len <= DEPTH_L);
    assign xfer   = bus.in_valid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        vcnt_d    = vcnt_q;
        sum_d     = sum_q;
        vsum_d    = vsum_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = S_LOAD;
                        len_d   = len;
                        addr_d  = '0;
                        sum_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LOAD: begin
                mem_addr = addr_q[ADDR_W-1:0];
                if (xfer) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.in_data;
                    sum_d     = sum_q + bus.in_data;
                    addr_d    = addr_q + ONE;
                    if (addr_q + ONE == len_q) begin
                        state_d = S_VERIFY;
                        vcnt_d  = '0;
                        vsum_d  = '0;
                    end
                end
            end
            S_VERIFY: begin
                // Address runs one cycle ahead of the data it returns.
                if (vcnt_q != len_q) mem_addr = vcnt_q[ADDR_W-1:0];
                if (vcnt_q != '0) vsum_d = vsum_q + bus.mem_rdata;
                if (vcnt_q == len_q) state_d = S_CHECK;
                else                 vcnt_d  = vcnt_q + ONE;
            end
            S_CHECK: begin
                state_d = (vsum_q == sum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_CHECK);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            vcnt_q     <= '0;
            sum_q      <= '0;
            vsum_q     <= '0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            vcnt_q     <= vcnt_d;
            sum_q      <= sum_d;
            vsum_q     <= vsum_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign checksum      = sum_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed loads from the test plan, then randomized
// loads with gaps, stray starts, bad lengths, readback faults and aborts.
module tb_program_loader;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   len;
    logic          cpu_hold, busy, done, error;
    logic [DW-1:0] checksum;
    logic [2:0]    dbg_state;

    program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    program_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .checksum (checksum),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            t_start = 0;
    int            we_cnt = 0;
    logic [AW-1:0] last_we_addr = '0;
    logic          fault = 1'b0;
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] prog [4] = '{8'h05, 8'h86, 8'h25, 8'hC0};

    // Ideal synchronous RAM; while fault is set, word 2 reads back with bit 0 flipped.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr] ^ ((fault && bus.mem_addr == 5'd2) ? 8'h01 : 8'h00);
    end

    // Reference model: words still to accept, cycles until the verdict, and the image.
    int            m_load_left = 0;
    int            m_wait = 0;
    int            m_len = 0;
    logic          m_done = 1'b0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_sum = '0;
    logic [DW-1:0] m_vs;
    logic [DW-1:0] exp_q [$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_load_left = 0;
            m_wait      = 0;
            m_done      = 1'b0;
            m_err       = 1'b0;
            m_sum       = '0;
        end else if (m_load_left > 0) begin
            if (bus.in_valid) begin
                exp_q.push_back(bus.in_data);
                m_sum = m_sum + bus.in_data;
                m_load_left--;
                if (m_load_left == 0) m_wait = m_len + 2;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_vs = '0;
                for (int i = 0; i < exp_q.size(); i++)
                    m_vs = m_vs + (exp_q[i] ^ ((fault && i == 2) ? 8'h01 : 8'h00));
                m_done = (m_vs == m_sum);
                m_err  = !m_done;
            end
        end else if (start) begin
            m_done = 1'b0;
            if (len >= 1 && len <= DEPTH) begin
                m_len       = int'(len);
                m_load_left = int'(len);
                m_sum       = '0;
                m_err       = 1'b0;
                exp_q.delete();
            end else begin
                m_err = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: one cycle-accurate check just before every rising edge.
    always begin
        @(negedge clk);
        #4;
        if (cyc >= 1) begin
            chk("in_ready", bus.in_ready, m_load_left > 0);
            chk("busy", busy, (m_load_left > 0) || (m_wait > 0));
            chk("done", done, m_done);
            chk("error", error, m_err);
            chk("cpu_hold", cpu_hold, !m_done);
            chk("checksum", checksum, m_sum);
            if (m_load_left > 0 && bus.in_valid) begin
                chk("mem_we", bus.mem_we, 1);
                chk("wr_addr", bus.mem_addr, exp_q.size());
                chk("wr_data", bus.mem_wdata, bus.in_data);
            end else begin
                chk("mem_we", bus.mem_we, 0);
                if (m_wait > 2) chk("rd_addr", bus.mem_addr, m_len + 2 - m_wait);
            end
            if (bus.mem_we) begin
                we_cnt++;
                last_we_addr = bus.mem_addr;
            end
        end
    end

    task automatic do_start(input int l);
        start   = 1'b1;
        len     = 6'(l);
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        len   = 6'($urandom);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("push_timeout", g, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            if (stray && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                len   = 6'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(output int edges);
        int g = 0;
        while (g < 200) begin
            @(posedge clk);
            #4;
            g++;
            if (done || error) break;
        end
        if (!(done || error)) chk("done_timeout", g, 0);
        edges = cyc - t_start;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int e;
        int l;
        int abort_at;
        bit aborted;

        reset = 1'b1;
        start = 1'b0;
        len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_checksum", checksum, 0);
        reset = 1'b0;
        @(negedge clk);

        // Four-byte program, no gaps.
        we_cnt = 0;
        do_start(4);
        for (int i = 0; i < 4; i++) push_byte(prog[i]);
        wait_done(e);
        chk("t1_latency", e, 11);
        chk("t1_checksum", checksum, 8'h70);
        chk("t1_done", done, 1);
        chk("t1_cpu_hold", cpu_hold, 0);
        chk("t1_error", error, 0);
        chk("t1_we_cnt", we_cnt, 4);
        for (int i = 0; i < 4; i++) chk("t1_ram", ram[i], prog[i]);

        // Same bytes, three idle cycles between the second and third.
        we_cnt = 0;
        do_start(4);
        push_byte(prog[0]);
        push_byte(prog[1]);
        idle(3, 1'b0);
        push_byte(prog[2]);
        push_byte(prog[3]);
        wait_done(e);
        chk("t2_latency", e, 14);
        chk("t2_checksum", checksum, 8'h70);
        chk("t2_we_cnt", we_cnt, 4);
        chk("t2_last_addr", last_we_addr, 3);

        // Illegal lengths, then a one-word load.
        we_cnt = 0;
        do_start(0);
        chk("t3_len0_error", error, 1);
        chk("t3_len0_hold", cpu_hold, 1);
        do_start(33);
        chk("t3_len33_error", error, 1);
        chk("t3_len33_hold", cpu_hold, 1);
        chk("t3_bad_we_cnt", we_cnt, 0);
        do_start(1);
        push_byte(8'hC0);
        wait_done(e);
        chk("t3_done", done, 1);
        chk("t3_checksum", checksum, 8'hC0);
        chk("t3_latency", e, 5);

        // Full-depth load with in_valid held high past the last word.
        we_cnt = 0;
        do_start(32);
        for (int i = 0; i < 32; i++) push_byte(8'(i));
        chk("t4_in_ready_low", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        wait_done(e);
        bus.in_valid = 1'b0;
        chk("t4_we_cnt", we_cnt, 32);
        chk("t4_last_addr", last_we_addr, 31);
        chk("t4_checksum", checksum, 8'hF0);
        chk("t4_done", done, 1);
        chk("t4_ram0", ram[0], 8'h00);

        // Corrupted readback of word 2.
        fault = 1'b1;
        do_start(4);
        for (int i = 0; i < 4; i++) push_byte(prog[i]);
        wait_done(e);
        chk("t5_error", error, 1);
        chk("t5_cpu_hold", cpu_hold, 1);
        chk("t5_done", done, 0);
        fault = 1'b0;

        // Reset after three of four bytes, then a clean reload.
        do_start(4);
        for (int i = 0; i < 3; i++) push_byte(prog[i]);
        pulse_reset();
        chk("t6_in_ready", bus.in_ready, 0);
        chk("t6_checksum", checksum, 0);
        chk("t6_cpu_hold", cpu_hold, 1);
        chk("t6_busy", busy, 0);
        do_start(4);
        for (int i = 0; i < 4; i++) push_byte(prog[i]);
        wait_done(e);
        chk("t6_done", done, 1);
        chk("t6_checksum2", checksum, 8'h70);

        // Randomized loads checked by the model.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 5) == 0) l = (t % 3 == 0) ? 0 : $urandom_range(33, 63);
            else l = $urandom_range(1, 32);
            fault = ($urandom_range(0, 3) == 0);
            do_start(l);
            if (l >= 1 && l <= 32) begin
                abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, l - 1) : -1;
                aborted = 1'b0;
                for (int i = 0; i < l; i++) begin
                    if (i == abort_at) begin
                        pulse_reset();
                        aborted = 1'b1;
                        break;
                    end
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
                    push_byte(8'($urandom));
                end
                if (!aborted) wait_done(e);
            end else begin
                idle(1, 1'b0);
            end
        end
        idle(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
